// File: rtl/input_fetch_arbiter_if.sv
// Input-fetch arbiter bus bundle.
// Groups the requester side (req, base_addr, input_ready), the input-memory
// read port (mem_rd_en, mem_addr, mem_rd_data) and the SNG register-file
// write port (wr_en, wr_sel, wr_index, wr_data) plus busy.
//   slave  : the arbiter itself
//   master : requesters + memory (the environment driving the arbiter)
interface input_fetch_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 9,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [NUM_REQ-1:0]                 req;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] base_addr;   // slice i belongs to requester i
    logic                               mem_rd_en;
    logic [ADDR_WIDTH-1:0]              mem_addr;
    logic [DATA_WIDTH-1:0]              mem_rd_data;
    logic                               wr_en;
    logic [NUM_REQ-1:0]                 wr_sel;
    logic [IDX_W-1:0]                   wr_index;
    logic [DATA_WIDTH-1:0]              wr_data;
    logic [NUM_REQ-1:0]                 input_ready;
    logic                               busy;

    modport slave (
        input  req, base_addr, mem_rd_data,
        output mem_rd_en, mem_addr, wr_en, wr_sel, wr_index, wr_data,
               input_ready, busy
    );

    modport master (
        output req, base_addr, mem_rd_data,
        input  mem_rd_en, mem_addr, wr_en, wr_sel, wr_index, wr_data,
               input_ready, busy
    );
endinterface

// File: rtl/input_fetch_arbiter.sv
// Round-robin arbiter that lets NUM_REQ SC tile controllers share one input
// memory. Each grant fetches a BURST_LEN-word window starting at the
// requester's base_addr and writes it into that requester's SNG input
// register file, then pulses input_ready to it.
// Ports:
//   clock  - sole clock, posedge
//   reset  - asynchronous, active-high
//   bus    - input_fetch_arbiter_if.slave (req/base_addr in, memory read
//            port, register-file write port, input_ready, busy)
module input_fetch_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 9,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input_fetch_arbiter_if.slave  bus
);
    localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, READY} state_t;

    state_t                state;
    logic [IDX_W-1:0]      cnt;
    logic [GNT_W-1:0]      grant;
    logic [GNT_W-1:0]      last_grant;
    logic [NUM_REQ-1:0]    grant_oh;

    logic                  mem_rd_en_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  wr_en_q;
    logic [NUM_REQ-1:0]    wr_sel_q;
    logic [IDX_W-1:0]      wr_index_q;
    logic [NUM_REQ-1:0]    input_ready_q;
    logic                  busy_q;

    // Round-robin pick: scan from the farthest candidate down to the nearest
    // so the last hit is the first set bit above last_grant.
    logic [GNT_W-1:0]      pick;

    always_comb begin
        pick = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.req[(int'(last_grant) + k) % NUM_REQ])
                pick = GNT_W'((int'(last_grant) + k) % NUM_REQ);
        end
    end

    assign grant_oh = NUM_REQ'(1) << grant;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            grant         <= '0;
            last_grant    <= GNT_W'(NUM_REQ - 1);
            mem_rd_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            wr_en_q       <= 1'b0;
            wr_sel_q      <= '0;
            wr_index_q    <= '0;
            input_ready_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        grant       <= pick;
                        mem_addr_q  <= bus.base_addr[pick];
                        mem_rd_en_q <= 1'b1;
                        cnt         <= '0;
                        busy_q      <= 1'b1;
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    // Write stage trails the read by the memory's 1-cycle latency.
                    wr_en_q    <= 1'b1;
                    wr_index_q <= cnt;
                    wr_sel_q   <= grant_oh;
                    if (cnt == IDX_W'(BURST_LEN - 1)) begin
                        mem_rd_en_q <= 1'b0;
                        mem_addr_q  <= '0;
                        state       <= DRAIN;
                    end else begin
                        cnt        <= cnt + 1'b1;
                        mem_addr_q <= mem_addr_q + 1'b1;   // base + cnt, wraps
                    end
                end
                DRAIN: begin
                    wr_en_q       <= 1'b0;
                    wr_sel_q      <= '0;
                    wr_index_q    <= '0;
                    input_ready_q <= grant_oh;
                    state         <= READY;
                end
                READY: begin
                    input_ready_q <= '0;
                    last_grant    <= grant;
                    busy_q        <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_rd_en   = mem_rd_en_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_sel      = wr_sel_q;
    assign bus.wr_index    = wr_index_q;
    // Gated so the write data bus stays quiet outside write cycles.
    assign bus.wr_data     = wr_en_q ? bus.mem_rd_data : '0;
    assign bus.input_ready = input_ready_q;
    assign bus.busy        = busy_q;
endmodule

// File: doc/input_fetch_arbiter.md
INPUT_FETCH_ARBITER -- requirements
Module: input_fetch_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of SC tile controllers sharing the input memory.
REQ-002 Parameter BURST_LEN, default 9, words fetched per grant (one 3x3 input window).
REQ-003 Parameter ADDR_WIDTH, default 16, memory address width.
REQ-004 Parameter DATA_WIDTH, default 8, input word width.
REQ-005 clock  input  1  sole clock; all state changes on posedge.
REQ-006 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-007 req  input  NUM_REQ  level request per controller (driven by the controller's input_req).
REQ-008 base_addr  input  NUM_REQ*ADDR_WIDTH  per-requester window start address; slice i belongs to requester i.
REQ-009 mem_rd_en  output  1  read strobe to the input memory; fixed 1-cycle read latency.
REQ-010 mem_addr  output  ADDR_WIDTH  read address.
REQ-011 mem_rd_data  input  DATA_WIDTH  read data, valid in the cycle after mem_rd_en.
REQ-012 wr_en  output  1  write strobe into the granted requester's SNG input register file.
REQ-013 wr_sel  output  NUM_REQ  one-hot target requester for wr_en.
REQ-014 wr_index  output  clog2(BURST_LEN)  word position within the window.
REQ-015 wr_data  output  DATA_WIDTH  mem_rd_data passed through.
REQ-016 input_ready  output  NUM_REQ  one-cycle pulse to the served requester.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, FETCH, DRAIN, READY.
REQ-019 IDLE: when any req bit is set, select the first set bit searching upward from (last_grant+1) mod NUM_REQ; register the grant index and its base_addr; enter FETCH; word counter cnt := 0.
REQ-020 IDLE with req == 0: remain in IDLE; all strobes low.
REQ-021 FETCH: mem_rd_en=1, mem_addr = latched base + cnt (modulo 2^ADDR_WIDTH); cnt increments each cycle; after the cycle with cnt == BURST_LEN-1, enter DRAIN.
REQ-022 wr_en is mem_rd_en delayed one cycle; wr_index is cnt delayed one cycle; wr_sel is the one-hot grant while wr_en=1, else 0.
REQ-023 DRAIN: exactly one cycle; carries the final write (wr_index = BURST_LEN-1); then enter READY.
REQ-024 READY: input_ready[grant]=1 for exactly one cycle; last_grant := grant; then enter IDLE.
REQ-025 Latency: req sampled in IDLE at cycle 0 -> FETCH cycles 1..BURST_LEN -> DRAIN at BURST_LEN+1 -> input_ready at cycle BURST_LEN+2.
REQ-026 Grant and latched base_addr do not change between IDLE exit and READY exit; req or base_addr changes during that time are ignored.
REQ-027 A requester that drops req mid-burst still receives its full burst and input_ready pulse.
REQ-028 Requests arriving while busy are held by the requester (level) and arbitrated at the next IDLE; no request is queued internally.
REQ-029 At most one bit of input_ready and wr_sel is high in any cycle.

Reset
REQ-030 On reset assertion, within the same cycle: state=IDLE, cnt=0, all outputs 0, last_grant=NUM_REQ-1 (requester 0 has top priority first).
REQ-031 Reset mid-burst aborts the fetch; no input_ready pulse is issued for the aborted grant.

Verification
REQ-032 Single request: req=4'b0100, base_addr[2]=0x0040 -> mem_addr 0x0040..0x0048 on cycles 1..9, wr_sel=4'b0100, input_ready=4'b0100 on cycle 11 only.
REQ-033 Round-robin: req=4'b1111 held -> grants 0,1,2,3,0 in order, each separated by 11 cycles, with IDLE cycles between grants.
REQ-034 Wrap: base_addr=0xFFFC -> mem_addr 0xFFFC,0xFFFD,0xFFFE,0xFFFF,0x0000..0x0004.
REQ-035 Request dropped at cycle 3 of burst -> all 9 writes complete, input_ready still pulses.
REQ-036 Reset asserted at cycle 5 of a burst -> outputs 0 immediately, no input_ready; after release with req=4'b0011, requester 0 is granted first.
